// File: rtl/team_00_wb_pkg.sv
// Shared types for the team_00 Wishbone classic initiator: FSM states,
// default bus widths and the latched request record.
package team_00_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    // Sized for the default widths; the top casts into and out of it.
    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] wdata;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/team_00_wb_master.sv
// Wishbone classic (B3) single-transfer initiator with a valid/ready request
// channel, a one-cycle response pulse and a bus-cycle timeout.
module team_00_wb_master
    import team_00_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_sel,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                WE_O,
    output logic                STB_O,
    output logic                CYC_O,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic                ACK_I
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high. req_ready is high only in IDLE, so at most one
    // request is in flight; rsp_valid has no backpressure and must be taken.

    wbm_state_t          state_q, state_d;
    wb_req_t             req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                timeout_hit;
    logic [DATA_W-1:0]   rdata_d;
    logic                err_d;

    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && !ACK_I && (cnt_inc == CNT_LIMIT);

        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = WB_ADDR_W'(req_addr);
                    req_d.wdata = WB_DATA_W'(req_wdata);
                    req_d.sel   = WB_SEL_W'(req_sel);
                    if (req_sel == '0) begin
                        // Empty byte-enable is illegal: answer without a bus cycle.
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (ACK_I) begin
                    state_d = RESP;
                    rdata_d = req_q.we ? '0 : DAT_I;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            rsp_valid <= (state_d == RESP);
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            CYC_O     <= (state_d == BUS);
            STB_O     <= (state_d == BUS);
            WE_O      <= (state_d == BUS) && req_d.we;
            ADR_O     <= (state_d == BUS) ? ADDR_W'(req_d.addr)  : '0;
            DAT_O     <= (state_d == BUS) ? DATA_W'(req_d.wdata) : '0;
            SEL_O     <= (state_d == BUS) ? SEL_W'(req_d.sel)    : '0;
        end
    end

endmodule

// File: tb/tb_team_00_wb_master.sv
// Bench for team_00_wb_master: two instances (timeout 8 and 4), a scheduled
// transaction model checked every cycle, and directed transactions with literals.
module tb_team_00_wb_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        req_valid[2];
    logic        req_we[2];
    logic [31:0] req_addr[2];
    logic [31:0] req_wdata[2];
    logic [3:0]  req_sel[2];
    logic        req_ready[2];
    logic        rsp_valid[2];
    logic [31:0] rsp_rdata[2];
    logic        rsp_err[2];
    logic        busy[2];
    logic [31:0] adr_o[2];
    logic [31:0] dat_o[2];
    logic [3:0]  sel_o[2];
    logic        we_o[2];
    logic        stb_o[2];
    logic        cyc_o[2];
    logic [31:0] dat_i[2];
    logic        ack_i[2];

    int n_vec = 0;
    int n_bad = 0;

    team_00_wb_master #(.TIMEOUT_CYCLES(8)) dut8 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_sel(req_sel[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
        .ADR_O(adr_o[0]), .DAT_O(dat_o[0]), .SEL_O(sel_o[0]), .WE_O(we_o[0]), .STB_O(stb_o[0]),
        .CYC_O(cyc_o[0]), .DAT_I(dat_i[0]), .ACK_I(ack_i[0])
    );

    team_00_wb_master #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_sel(req_sel[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
        .ADR_O(adr_o[1]), .DAT_O(dat_o[1]), .SEL_O(sel_o[1]), .WE_O(we_o[1]), .STB_O(stb_o[1]),
        .CYC_O(cyc_o[1]), .DAT_I(dat_i[1]), .ACK_I(ack_i[1])
    );

    // Slave: acks on STB cycle number ack_delay+1 (never if ack_delay < 0);
    // DAT_I carries junk except in the ack cycle.
    int          ack_delay[2];
    logic [31:0] slv_data[2];
    int          stb_cnt[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) stb_cnt[i] <= cyc_o[i] ? stb_cnt[i] + 1 : 0;
    end

    for (genvar g = 0; g < 2; g++) begin : g_slv
        assign ack_i[g] = cyc_o[g] && (stb_cnt[g] == ack_delay[g]);
        assign dat_i[g] = ack_i[g] ? slv_data[g] : (32'hBAD0_0000 + 32'(stb_cnt[g]));
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %h want %h", name, i, $time, act, exp);
        end
    endtask

    // Model: each accepted request becomes a schedule (accept edge, bus length,
    // response values) derived from the slave delay and the timeout limit.
    int          tmo[2] = '{8, 4};
    bit          m_busy[2];
    int          m_start[2];
    int          m_len[2];
    logic        m_we[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_sel[2];
    logic [31:0] m_rdata_next[2];
    logic        m_err_next[2];
    logic [31:0] m_rdata[2];
    logic        m_err[2];
    int          t_edge = 0;

    task automatic model_step(input int i);
        if (rst[i]) begin
            m_busy[i]  = 1'b0;
            m_rdata[i] = 32'h0;
            m_err[i]   = 1'b0;
        end else begin
            if (m_busy[i] && t_edge == m_start[i] + m_len[i] + 1) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i] && req_valid[i]) begin
                m_busy[i]  = 1'b1;
                m_start[i] = t_edge;
                m_we[i]    = req_we[i];
                m_addr[i]  = req_addr[i];
                m_wdata[i] = req_wdata[i];
                m_sel[i]   = req_sel[i];
                if (req_sel[i] == 4'h0) begin
                    m_len[i] = 0;
                    m_err_next[i] = 1'b1;
                    m_rdata_next[i] = 32'h0;
                end else if (ack_delay[i] >= 0 && (tmo[i] == 0 || ack_delay[i] < tmo[i])) begin
                    m_len[i] = ack_delay[i] + 1;
                    m_err_next[i] = 1'b0;
                    m_rdata_next[i] = req_we[i] ? 32'h0 : slv_data[i];
                end else begin
                    m_len[i] = tmo[i];
                    m_err_next[i] = 1'b1;
                    m_rdata_next[i] = 32'h0;
                end
            end
            if (m_busy[i] && t_edge == m_start[i] + m_len[i]) begin
                m_rdata[i] = m_rdata_next[i];
                m_err[i]   = m_err_next[i];
            end
        end
    endtask

    task automatic model_check(input int i);
        bit cyc_e, rsp_e;
        cyc_e = m_busy[i] && t_edge >= m_start[i] && t_edge < m_start[i] + m_len[i];
        rsp_e = m_busy[i] && t_edge == m_start[i] + m_len[i];
        chk("req_ready", i, 32'(req_ready[i]), 32'(!m_busy[i]));
        chk("busy", i, 32'(busy[i]), 32'(m_busy[i]));
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(rsp_e));
        chk("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
        chk("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
        chk("CYC_O", i, 32'(cyc_o[i]), 32'(cyc_e));
        chk("STB_O", i, 32'(stb_o[i]), 32'(cyc_e));
        chk("WE_O", i, 32'(we_o[i]), 32'(cyc_e && m_we[i]));
        chk("ADR_O", i, adr_o[i], cyc_e ? m_addr[i] : 32'h0);
        chk("DAT_O", i, dat_o[i], cyc_e ? m_wdata[i] : 32'h0);
        chk("SEL_O", i, 32'(sel_o[i]), cyc_e ? 32'(m_sel[i]) : 32'h0);
    endtask

    always @(posedge clk) begin
        t_edge++;
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) model_check(i);
    end

    // Present one request, then check bus shape and response against literals.
    task automatic do_txn(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic [31:0] sdata, input int delay,
                          input int exp_cyc, input logic exp_err, input logic [31:0] exp_rdata);
        bit acc = 0;
        bit got = 0;
        int ncyc = 0;
        @(negedge clk);
        ack_delay[i] = delay;
        slv_data[i]  = sdata;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_sel[i]   = sel;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[i]) begin
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", i, 32'(acc), 32'h1);
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            req_valid[i] = 1'b0;
            if (cyc_o[i]) begin
                ncyc++;
                chk("lit_adr", i, adr_o[i], addr);
                chk("lit_sel", i, 32'(sel_o[i]), 32'(sel));
                chk("lit_we", i, 32'(we_o[i]), 32'(we));
                if (we) chk("lit_dat", i, dat_o[i], wdata);
            end
            if (rsp_valid[i]) begin
                got = 1;
                chk("lit_rdata", i, rsp_rdata[i], exp_rdata);
                chk("lit_err", i, 32'(rsp_err[i]), 32'(exp_err));
                break;
            end
        end
        chk("lit_rsp_seen", i, 32'(got), 32'h1);
        chk("lit_cyc_len", i, 32'(ncyc), 32'(exp_cyc));
        @(negedge clk);
        chk("lit_ready_after", i, 32'(req_ready[i]), 32'h1);
        chk("lit_pulse_1cyc", i, 32'(rsp_valid[i]), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i] = 1'b0;
            req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0;
            req_sel[i] = 4'h0;
            ack_delay[i] = -1;
            slv_data[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(req_ready[i]), 32'h1);
            chk("rst_cyc", i, 32'(cyc_o[i]), 32'h0);
            chk("rst_rsp", i, 32'(rsp_valid[i]), 32'h0);
        end

        do_txn(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 32'h5555_5555, 0, 1, 1'b0, 32'h0);
        do_txn(0, 1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h1234_5678, 3, 4, 1'b0, 32'h1234_5678);
        do_txn(0, 1'b0, 32'h3000_0030, 32'h0, 4'h3, 32'h9999_9999, -1, 8, 1'b1, 32'h0);
        do_txn(1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 3, 4, 1'b0, 32'hCAFE_F00D);
        do_txn(1, 1'b0, 32'h4000_0004, 32'h0, 4'hF, 32'h7777_7777, 4, 4, 1'b1, 32'h0);
        do_txn(0, 1'b1, 32'h3000_0040, 32'h1111_2222, 4'h0, 32'h0, 0, 0, 1'b1, 32'h0);
        do_txn(1, 1'b1, 32'h4000_0008, 32'hA5A5_0F0F, 4'hC, 32'h0, 2, 3, 1'b0, 32'h0);

        // Reset in the middle of wait states.
        @(negedge clk);
        ack_delay[0] = -1;
        req_we[0] = 1'b0;
        req_addr[0] = 32'h3000_0050;
        req_sel[0] = 4'hF;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mid_cyc_before_rst", 0, 32'(cyc_o[0]), 32'h1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rst_mid_cyc", 0, 32'(cyc_o[0]), 32'h0);
        chk("rst_mid_stb", 0, 32'(stb_o[0]), 32'h0);
        chk("rst_mid_adr", 0, adr_o[0], 32'h0);
        chk("rst_mid_ready", 0, 32'(req_ready[0]), 32'h1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid[0]) seen = 1;
            @(negedge clk);
        end
        chk("rst_mid_no_rsp", 0, 32'(seen), 32'h0);

        do_txn(0, 1'b0, 32'h3000_0060, 32'h0, 4'hF, 32'h5A5A_A5A5, 1, 2, 1'b0, 32'h5A5A_A5A5);
        do_txn(1, 1'b0, 32'h4000_000C, 32'h0, 4'h1, 32'h0BAD_CAFE, 0, 1, 1'b0, 32'h0BAD_CAFE);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
